// File: rtl/voxel_gpu_pkg.sv
// Shared types and constants for the voxel GPU fill engine.
package voxel_gpu_pkg;

  // Fill engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fill_state_e;

  // One RGB565 pixel; a bus word carries two of them
  typedef logic [15:0] rgb565_t;

  localparam int unsigned WORD_BYTES        = 4;
  localparam int unsigned DEFAULT_ROW_PITCH = 1024;

endpackage

// File: rtl/voxel_fill_addr_gen.sv
// Column/row counters for the fill walk, end-of-row wrap, last-beat flag
// and the byte address of the beat the counters will point at next cycle.
module voxel_fill_addr_gen
  import voxel_gpu_pkg::*;
#(
  parameter int unsigned H_WORDS   = 160,
  parameter int unsigned ROWS      = 240,
  parameter int unsigned ROW_PITCH = DEFAULT_ROW_PITCH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,      // restart the walk at (0,0)
  input  logic        advance,    // a beat was accepted
  input  logic [31:0] base,       // base address valid in this cycle
  output logic        last_beat,  // counters sit on the final beat
  output logic [31:0] addr_next   // address for the updated counters
);

  localparam int unsigned CW = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          row_end;

  // Next counter values and the address they select (32-bit wrapping sum)
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    row_end   = (col_q == CW'(H_WORDS - 1));
    last_beat = row_end && (row_q == RW'(ROWS - 1));
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (row_end) begin
        col_d = '0;
        row_d = last_beat ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    addr_next = base + (32'(row_d) * 32'(ROW_PITCH)) + (32'(col_d) * 32'(WORD_BYTES));
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/voxel_fill_dma.sv
// Rectangle fill DMA: writes {color,color} over ROWS x H_WORDS words through
// an Avalon-MM write master, then pulses done.
// Optional macro VOXEL_FILL_ABORT_EN adds an abort input that ends the fill
// early after the beat currently on the bus is accepted.
module voxel_fill_dma
  import voxel_gpu_pkg::*;
#(
  parameter int unsigned H_WORDS   = 160,
  parameter int unsigned ROWS      = 240,
  parameter int unsigned ROW_PITCH = DEFAULT_ROW_PITCH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] buffer_addr,
  input  logic [15:0] color,
`ifdef VOXEL_FILL_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] m1_address,
  output logic [31:0] m1_writedata,
  output logic        m1_write,
  input  logic        m1_waitrequest,
  output logic        m1_read
);

  fill_state_e state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        clear, advance, accept, stop_now;
  logic        last_beat;
  logic [31:0] addr_next;

`ifdef VOXEL_FILL_ABORT_EN
  // Abort is remembered so a short pulse during a stall still ends the fill
  logic abort_req_q, abort_req_d;
`endif

  voxel_fill_addr_gen #(
    .H_WORDS  (H_WORDS),
    .ROWS     (ROWS),
    .ROW_PITCH(ROW_PITCH)
  ) u_addr_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .advance  (advance),
    .base     (base_d),
    .last_beat(last_beat),
    .addr_next(addr_next)
  );

  // Beat handshake: the word on the bus moves only when the slave is not stalling
  assign accept = wr_q && !m1_waitrequest;

`ifdef VOXEL_FILL_ABORT_EN
  assign stop_now = last_beat || abort || abort_req_q;
`else
  assign stop_now = last_beat;
`endif

  // Next-state and registered bus outputs
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    clear   = 1'b0;
    advance = 1'b0;
`ifdef VOXEL_FILL_ABORT_EN
    abort_req_d = abort_req_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef VOXEL_FILL_ABORT_EN
        abort_req_d = 1'b0;
`endif
        if (start) begin
          base_d  = buffer_addr & ~32'd3;
          data_d  = {rgb565_t'(color), rgb565_t'(color)};
          clear   = 1'b1;
          addr_d  = addr_next;
          wr_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef VOXEL_FILL_ABORT_EN
        if (abort) abort_req_d = 1'b1;
`endif
        if (accept) begin
          advance = 1'b1;
          if (stop_now) begin
            wr_d    = 1'b0;
            state_d = DONE;
          end else begin
            addr_d = addr_next;
          end
        end
      end
      DONE: begin
        wr_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        wr_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and bus registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
`ifdef VOXEL_FILL_ABORT_EN
      abort_req_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
`ifdef VOXEL_FILL_ABORT_EN
      abort_req_q <= abort_req_d;
`endif
    end
  end

  assign m1_address   = addr_q;
  assign m1_writedata = data_q;
  assign m1_write     = wr_q;
  assign m1_read      = 1'b0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_voxel_fill_dma.sv
// Directed bench for voxel_fill_dma with a 2x2-word fill.
module tb_voxel_fill_dma;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] buffer_addr;
  logic [15:0] color;
  logic        busy, done, m1_write, m1_waitrequest, m1_read;
  logic [31:0] m1_address, m1_writedata;
`ifdef VOXEL_FILL_ABORT_EN
  logic        abort;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];
  logic [31:0] stall_addr[$];
  logic [31:0] stall_data[$];
  int          n_done;
  int          done_cyc;

  always #5 clock = ~clock;

  voxel_fill_dma #(.H_WORDS(2), .ROWS(2), .ROW_PITCH(1024)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .buffer_addr   (buffer_addr),
    .color         (color),
`ifdef VOXEL_FILL_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .done          (done),
    .m1_address    (m1_address),
    .m1_writedata  (m1_writedata),
    .m1_write      (m1_write),
    .m1_waitrequest(m1_waitrequest),
    .m1_read       (m1_read)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one start then watch 16 cycles; cycle k is the k-th cycle after the
  // start cycle. Beat stall_beat (0-based) is held off for stall_n cycles;
  // a second start with colour 0x001F is driven in cycle restart_cyc;
  // abort is driven in cycle abort_cyc (abort builds only).
  task automatic run_fill(input logic [31:0] base, input logic [15:0] col,
                          input int stall_beat, input int stall_n,
                          input int restart_cyc, input int abort_cyc);
    int beats = 0;
    int stalls = 0;
    addr_log.delete(); data_log.delete();
    stall_addr.delete(); stall_data.delete();
    n_done = 0; done_cyc = -1;
    @(negedge clock);
    start = 1'b1; buffer_addr = base; color = col;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      start = (k == restart_cyc);
      if (start) color = 16'h001F;
`ifdef VOXEL_FILL_ABORT_EN
      abort = (k == abort_cyc);
`else
      if (abort_cyc < 0) ;
`endif
      if (m1_write && beats == stall_beat && stalls < stall_n) begin
        m1_waitrequest = 1'b1;
        stalls++;
        stall_addr.push_back(m1_address);
        stall_data.push_back(m1_writedata);
      end else begin
        m1_waitrequest = 1'b0;
      end
      if (m1_write && !m1_waitrequest) begin
        addr_log.push_back(m1_address);
        data_log.push_back(m1_writedata);
        beats++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
    start = 1'b0; m1_waitrequest = 1'b0;
`ifdef VOXEL_FILL_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic chk_std_fill(input string tag, input logic [31:0] base, input logic [31:0] data);
    logic [31:0] exp_a[4];
    exp_a[0] = base; exp_a[1] = base + 32'h4;
    exp_a[2] = base + 32'h400; exp_a[3] = base + 32'h404;
    chk({tag, "_nbeats"}, addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), addr_log[i], exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), data_log[i], data);
    end
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_busy_end"}, {31'd0, busy}, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; buffer_addr = '0; color = '0; m1_waitrequest = 1'b0;
`ifdef VOXEL_FILL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_done",  {31'd0, done}, 0);
    chk("rst_write", {31'd0, m1_write}, 0);
    chk("rst_addr",  m1_address, 0);
    chk("rst_data",  m1_writedata, 0);
    chk("rst_read",  {31'd0, m1_read}, 0);
    reset_n = 1'b1;

    // Zero-wait fill; start sampled right after reset release
    run_fill(32'h0800_0000, 16'hF800, -1, 0, -1, -1);
    chk_std_fill("zw", 32'h0800_0000, 32'hF800F800);
    chk("zw_done_cyc", done_cyc, 5);

    // Three-cycle stall on the second beat
    run_fill(32'h0800_0000, 16'hF800, 1, 3, -1, -1);
    chk_std_fill("st", 32'h0800_0000, 32'hF800F800);
    chk("st_done_cyc", done_cyc, 8);
    chk("st_nstall", stall_addr.size(), 3);
    for (int i = 0; i < stall_addr.size(); i++) begin
      chk($sformatf("st_hold_addr%0d", i), stall_addr[i], 32'h0800_0004);
      chk($sformatf("st_hold_data%0d", i), stall_data[i], 32'hF800F800);
    end

    // Start while busy, and start during DONE: both ignored
    run_fill(32'h0800_0000, 16'hF800, -1, 0, 2, -1);
    chk_std_fill("rs2", 32'h0800_0000, 32'hF800F800);
    run_fill(32'h0800_0000, 16'hF800, -1, 0, 5, -1);
    chk_std_fill("rs5", 32'h0800_0000, 32'hF800F800);
    chk("rs5_done_cyc", done_cyc, 5);

    // Unaligned base near top of memory wraps modulo 2^32
    run_fill(32'hFFFF_FFFE, 16'h07E0, -1, 0, -1, -1);
    chk("wr_nbeats", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wr_addr0", addr_log[0], 32'hFFFF_FFFC);
      chk("wr_addr1", addr_log[1], 32'h0000_0000);
      chk("wr_addr2", addr_log[2], 32'h0000_03FC);
      chk("wr_addr3", addr_log[3], 32'h0000_0400);
      chk("wr_data0", data_log[0], 32'h07E007E0);
    end

    // Reset while the second beat is stalled
    @(negedge clock);
    start = 1'b1; buffer_addr = 32'h0800_0000; color = 16'hF800;
    @(negedge clock);
    start = 1'b0; m1_waitrequest = 1'b0;
    @(negedge clock);
    m1_waitrequest = 1'b1;
    @(negedge clock);
    chk("rm_stalled", {31'd0, m1_write}, 1);
    reset_n = 1'b0;
    #1;
    chk("rm_write", {31'd0, m1_write}, 0);
    chk("rm_busy",  {31'd0, busy}, 0);
    chk("rm_addr",  m1_address, 0);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (done) n_done++;
    end
    reset_n = 1'b1; m1_waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (done || m1_write) n_done++;
    end
    chk("rm_no_done", n_done, 0);
    run_fill(32'h0800_0000, 16'hF800, -1, 0, -1, -1);
    chk_std_fill("rm_after", 32'h0800_0000, 32'hF800F800);
    chk("rm_after_done_cyc", done_cyc, 5);

`ifdef VOXEL_FILL_ABORT_EN
    // Abort alongside the first accepted beat
    run_fill(32'h0800_0000, 16'hF800, -1, 0, -1, 1);
    chk("ab_nbeats", addr_log.size(), 1);
    chk("ab_ndone", n_done, 1);
    chk("ab_done_cyc", done_cyc, 2);
    chk("ab_busy_end", {31'd0, busy}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/voxel_fill_dma.md
VOXEL_FILL_DMA -- requirements
Module: voxel_fill_dma

Interface
REQ-001 The block SHALL have parameter H_WORDS, default 160: 32-bit words per row (two 16-bit pixels per word).
REQ-002 The block SHALL have parameter ROWS, default 240: rows per fill.
REQ-003 The block SHALL have parameter ROW_PITCH, default 1024: byte distance between row starts.
REQ-004 The block SHALL have port `clock`, input, 1 bit: single clock for all logic.
REQ-005 The block SHALL have port `reset_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port `start`, input, 1 bit: one-cycle fill request.
REQ-007 The block SHALL have port `buffer_addr`, input, 32 bits: fill base byte address.
REQ-008 The block SHALL have port `color`, input, 16 bits: RGB565 fill colour.
REQ-009 The block SHALL have port `busy`, output, 1 bit: fill in progress.
REQ-010 The block SHALL have port `done`, output, 1 bit: one-cycle completion pulse, usable as `irq`.
REQ-011 The block SHALL have port `m1_address`, output, 32 bits: Avalon-MM master address.
REQ-012 The block SHALL have port `m1_writedata`, output, 32 bits: Avalon-MM master write data.
REQ-013 The block SHALL have port `m1_write`, output, 1 bit: Avalon-MM master write strobe.
REQ-014 The block SHALL have port `m1_waitrequest`, input, 1 bit: Avalon-MM slave stall.
REQ-015 The block SHALL have port `m1_read`, output, 1 bit: tied 0.
REQ-016 The block SHALL have port `abort`, input, 1 bit, only when VOXEL_FILL_ABORT_EN is defined.

Function
REQ-017 The state machine SHALL have exactly three states: IDLE, WRITE and DONE.
REQ-018 In IDLE, `start`=1 SHALL latch `buffer_addr` (bits [1:0] forced to 0) and `{color,color}`, clear the column and row counters, and enter WRITE on the next cycle.
REQ-019 `start` SHALL be ignored in WRITE and DONE, with no relatch and no restart.
REQ-020 In WRITE, `m1_write` SHALL be 1 and `m1_address` SHALL equal base + row*ROW_PITCH + col*4, computed as a 32-bit sum that wraps modulo 2^32.
REQ-021 `m1_address`, `m1_writedata` and `m1_write` SHALL be registered and SHALL hold stable while `m1_waitrequest`=1.
REQ-022 A beat SHALL be accepted only on a cycle where `m1_write`=1 and `m1_waitrequest`=0; each accepted beat SHALL advance `col`, and `col`=H_WORDS-1 SHALL wrap `col` to 0 and increment `row`.
REQ-023 On acceptance of the beat with `col`=H_WORDS-1 and `row`=ROWS-1, the next state SHALL be DONE, and `m1_write` SHALL be 0 in the following cycle.
REQ-024 DONE SHALL last exactly one cycle with `done`=1, then return to IDLE.
REQ-025 With zero wait states, a fill SHALL take H_WORDS*ROWS write cycles, and `done` SHALL assert in the cycle after the last accepted beat.
REQ-026 `busy` SHALL be 1 in WRITE and DONE and 0 in IDLE.
REQ-027 The block SHALL never issue more than H_WORDS*ROWS writes per start and SHALL never issue a write outside WRITE.

Reset
REQ-028 `reset_n`=0 SHALL asynchronously force IDLE, clear the counters, and set `m1_write`, `busy`, `done`, `m1_address` and `m1_writedata` to 0.
REQ-029 Reset mid-fill SHALL abandon the fill immediately, including a beat stalled by waitrequest, and SHALL NOT produce `done`.
REQ-030 After reset release, the first `start` SHALL be honoured in the cycle it is sampled.

Configuration
REQ-031 With macro VOXEL_FILL_ABORT_EN defined, `abort`=1 in WRITE SHALL complete a beat that is pending under waitrequest, then go to DONE, pulsing `done`.
REQ-032 With VOXEL_FILL_ABORT_EN defined, `abort`=1 with no beat pending SHALL go to DONE on the next cycle.
REQ-033 Without VOXEL_FILL_ABORT_EN, the `abort` port and its logic SHALL be absent, and a fill SHALL always run to completion.

Structure
REQ-034 Package voxel_gpu_pkg SHALL hold the fill state enum, the RGB565 pixel typedef, and the constants for word size (4) and default row pitch.
REQ-035 Sub-module voxel_fill_addr_gen SHALL hold the col/row counters, the wrap and last-beat detection, and the address sum.

Verification (bench params H_WORDS=2, ROWS=2, ROW_PITCH=1024)
REQ-036 Zero-wait fill: start with buffer_addr=0x0800_0000 and color=0xF800 -> writes to 0x0800_0000, 0x0800_0004, 0x0800_0400, 0x0800_0404, all with data 0xF800F800; `done` pulses in cycle 5 after the start cycle.
REQ-037 Waitrequest stall: `m1_waitrequest` held 1 for 3 cycles on beat 2 -> address and data stay stable for those cycles, exactly 4 writes total, and `done` is delayed by 3 cycles.
REQ-038 Start during busy: a second start with color=0x001F mid-fill -> all data remains 0xF800F800 and only one `done` pulse occurs.
REQ-039 Unaligned base and wrap: buffer_addr=0xFFFF_FFFE -> first write address 0xFFFF_FFFC and second write address 0x0000_0000.
REQ-040 Reset mid-stall: `reset_n` low during a stalled beat -> `m1_write`=0 immediately, no `done`, and a new start then runs a full 4-beat fill.
REQ-041 With VOXEL_FILL_ABORT_EN defined, abort after beat 1 -> exactly 1 write is accepted, then one `done` pulse, then IDLE.
